gfx_span_rasterizer: RTL and testbench

// - Multi-lane rect rasterizer: emits LANES horizontally adjacent pixels per beat plus a lane mask, replacing one-pixel-per-ack rect generation.
// - Clips to the clip window, generates texture u/v per beat, and limits the span to the texture source window.
// - Sits between the command decoder and the fragment/clip pipeline; output uses a valid/ready stream with last-beat marker.

---
 rtl/gfx_raster_pkg.sv | 28 ++
 rtl/gfx_raster_bounds.sv | 74 +++++++
 rtl/gfx_span_rasterizer.sv | 240 ++++++++++++++++++++++++
 tb/tb_gfx_span_rasterizer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_raster_pkg.sv
// Shared types and helpers for the span rasterizer and the setup blocks
// that feed it.
package gfx_raster_pkg;

    localparam int POINT_W   = 16;
    localparam int MAX_LANES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic        [POINT_W-1:0] point_t;
    typedef logic signed [POINT_W:0]   spoint_t;

    // Bit i is set when pixel x+i still lies on or before the inclusive right bound x1.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int x, input int x1);
        logic [MAX_LANES-1:0] m;
        m = {MAX_LANES{1'b0}};
        for (int i = 0; i < MAX_LANES; i++) begin
            m[i] = ((x + i) <= x1);
        end
        return m;
    endfunction

endpackage

// File: rtl/gfx_raster_bounds.sv
// Combinational rectangle bound calculation: clip window, texture source
// window limit, texture origin and empty detection.
module gfx_raster_bounds
    import gfx_raster_pkg::*;
#(
    parameter int point_width = 16
) (
    input  logic                          i_clip_en,
    input  logic                          i_tex_en,
    input  logic        [point_width-1:0] i_dest_p0_x,
    input  logic        [point_width-1:0] i_dest_p0_y,
    input  logic        [point_width-1:0] i_dest_p1_x,
    input  logic        [point_width-1:0] i_dest_p1_y,
    input  logic        [point_width-1:0] i_clip_p0_x,
    input  logic        [point_width-1:0] i_clip_p0_y,
    input  logic        [point_width-1:0] i_clip_p1_x,
    input  logic        [point_width-1:0] i_clip_p1_y,
    input  logic        [point_width-1:0] i_src_p0_x,
    input  logic        [point_width-1:0] i_src_p0_y,
    input  logic        [point_width-1:0] i_src_p1_x,
    input  logic        [point_width-1:0] i_src_p1_y,
    output logic signed [point_width:0]   o_x0,
    output logic signed [point_width:0]   o_x1,
    output logic signed [point_width:0]   o_y0,
    output logic signed [point_width:0]   o_y1,
    output logic        [point_width-1:0] o_u0,
    output logic        [point_width-1:0] o_v0,
    output logic                          o_empty
);

    typedef logic signed [point_width:0] sw_t;
    typedef logic        [point_width-1:0] pw_t;

    localparam sw_t ONE_S = sw_t'(1'b1);

    function automatic sw_t sext(input pw_t a);
        return {a[point_width-1], a};
    endfunction

    function automatic sw_t zext(input pw_t a);
        return {1'b0, a};
    endfunction

    // One axis: dest is signed, clip and source windows are unsigned; ends are exclusive.
    function automatic void axis(input sw_t p0, input sw_t p1, input sw_t c0, input sw_t c1,
                                 input sw_t s0, input sw_t s1, input logic clip, input logic tex,
                                 output sw_t lo, output sw_t hi, output pw_t t0);
        sw_t t;
        sw_t lim;
        lo  = (clip && (c0 > p0)) ? c0 : p0;
        hi  = p1 - ONE_S;
        hi  = (clip && ((c1 - ONE_S) < hi)) ? (c1 - ONE_S) : hi;
        t   = s0 + (lo - p0);
        lim = lo + s1 - ONE_S - t;
        hi  = (tex && (lim < hi)) ? lim : hi;
        t0  = t[point_width-1:0];
    endfunction

    // Both axes share the same rule set.
    always_comb begin
        o_x0 = {(point_width+1){1'b0}};
        o_x1 = {(point_width+1){1'b0}};
        o_y0 = {(point_width+1){1'b0}};
        o_y1 = {(point_width+1){1'b0}};
        o_u0 = {point_width{1'b0}};
        o_v0 = {point_width{1'b0}};
        axis(sext(i_dest_p0_x), sext(i_dest_p1_x), zext(i_clip_p0_x), zext(i_clip_p1_x),
             zext(i_src_p0_x), zext(i_src_p1_x), i_clip_en, i_tex_en, o_x0, o_x1, o_u0);
        axis(sext(i_dest_p0_y), sext(i_dest_p1_y), zext(i_clip_p0_y), zext(i_clip_p1_y),
             zext(i_src_p0_y), zext(i_src_p1_y), i_clip_en, i_tex_en, o_y0, o_y1, o_v0);
        o_empty = (o_x0 > o_x1) || (o_y0 > o_y1);
    end

endmodule

// File: rtl/gfx_span_rasterizer.sv
// Multi-lane rect rasterizer: walks the clipped rectangle LANES pixels per
// beat on a valid/ready stream, with optional texture coordinates.
module gfx_span_rasterizer
    import gfx_raster_pkg::*;
#(
    parameter int point_width = 16,
    parameter int LANES       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   clipping_enable_i,
    input  logic                   texture_enable_i,
    input  logic [point_width-1:0] dest_p0_x_i,
    input  logic [point_width-1:0] dest_p0_y_i,
    input  logic [point_width-1:0] dest_p1_x_i,
    input  logic [point_width-1:0] dest_p1_y_i,
    input  logic [point_width-1:0] clip_p0_x_i,
    input  logic [point_width-1:0] clip_p0_y_i,
    input  logic [point_width-1:0] clip_p1_x_i,
    input  logic [point_width-1:0] clip_p1_y_i,
    input  logic [point_width-1:0] src_p0_x_i,
    input  logic [point_width-1:0] src_p0_y_i,
    input  logic [point_width-1:0] src_p1_x_i,
    input  logic [point_width-1:0] src_p1_y_i,
    output logic                   busy_o,
    output logic                   ack_o,
    output logic                   pix_valid_o,
    input  logic                   pix_ready_i,
    output logic [point_width-1:0] x_o,
    output logic [point_width-1:0] y_o,
    output logic [point_width-1:0] u_o,
    output logic [point_width-1:0] v_o,
    output logic [LANES-1:0]       lane_mask_o,
    output logic                   last_o
);

    typedef logic signed [point_width:0]   sw_t;
    typedef logic        [point_width-1:0] pw_t;

    localparam sw_t LANES_S = sw_t'(LANES);
    localparam pw_t LANES_U = pw_t'(LANES);
    localparam sw_t ONE_S   = sw_t'(1'b1);
    localparam pw_t ONE_U   = pw_t'(1'b1);
    localparam sw_t ZERO_S  = sw_t'(1'b0);
    localparam pw_t ZERO_U  = pw_t'(1'b0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_ack;
    logic             r_valid;
    logic             r_last;
    logic [LANES-1:0] r_mask;
    logic             r_tex;
    sw_t              r_x0;
    sw_t              r_x1;
    sw_t              r_y1;
    pw_t              r_u0;
    sw_t              r_x;
    sw_t              r_y;
    pw_t              r_u;
    pw_t              r_v;

    sw_t              w_b_x0;
    sw_t              w_b_x1;
    sw_t              w_b_y0;
    sw_t              w_b_y1;
    pw_t              w_b_u0;
    pw_t              w_b_v0;
    logic             w_b_empty;

    logic             w_valid_nxt;
    sw_t              w_x_nxt;
    sw_t              w_y_nxt;
    pw_t              w_u_nxt;
    pw_t              w_v_nxt;
    sw_t              w_lim_x1;
    sw_t              w_lim_y1;
    logic             w_row_end;
    logic [LANES-1:0] w_mask_nxt;
    logic             w_last_nxt;

    gfx_raster_bounds #(
        .point_width (point_width)
    ) u_bounds (
        .i_clip_en   (clipping_enable_i),
        .i_tex_en    (texture_enable_i),
        .i_dest_p0_x (dest_p0_x_i),
        .i_dest_p0_y (dest_p0_y_i),
        .i_dest_p1_x (dest_p1_x_i),
        .i_dest_p1_y (dest_p1_y_i),
        .i_clip_p0_x (clip_p0_x_i),
        .i_clip_p0_y (clip_p0_y_i),
        .i_clip_p1_x (clip_p1_x_i),
        .i_clip_p1_y (clip_p1_y_i),
        .i_src_p0_x  (src_p0_x_i),
        .i_src_p0_y  (src_p0_y_i),
        .i_src_p1_x  (src_p1_x_i),
        .i_src_p1_y  (src_p1_y_i),
        .o_x0        (w_b_x0),
        .o_x1        (w_b_x1),
        .o_y0        (w_b_y0),
        .o_y1        (w_b_y1),
        .o_u0        (w_b_u0),
        .o_v0        (w_b_v0),
        .o_empty     (w_b_empty)
    );

    assign w_row_end = ((r_x + LANES_S) > r_x1);

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next beat position; SETUP uses the live bounds since they are not registered yet.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_u_nxt     = r_u;
        w_v_nxt     = r_v;
        w_lim_x1    = r_x1;
        w_lim_y1    = r_y1;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_lim_x1 = w_b_x1;
                w_lim_y1 = w_b_y1;
                if (w_b_empty) begin
                    w_state_nxt = ST_DONE;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_valid_nxt = 1'b1;
                    w_x_nxt     = w_b_x0;
                    w_y_nxt     = w_b_y0;
                    w_u_nxt     = texture_enable_i ? w_b_u0 : ZERO_U;
                    w_v_nxt     = texture_enable_i ? w_b_v0 : ZERO_U;
                end
            end
            ST_RUN: begin
                if (r_valid && pix_ready_i) begin
                    if (r_last) begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                    end else if (w_row_end) begin
                        w_x_nxt = r_x0;
                        w_u_nxt = r_u0;
                        w_y_nxt = r_y + ONE_S;
                        w_v_nxt = r_tex ? (r_v + ONE_U) : ZERO_U;
                    end else begin
                        w_x_nxt = r_x + LANES_S;
                        w_u_nxt = r_tex ? (r_u + LANES_U) : ZERO_U;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Lane mask and last flag for the beat about to be presented.
    always_comb begin
        if (w_valid_nxt) begin
            w_mask_nxt = LANES'(lane_mask(int'(w_x_nxt), int'(w_lim_x1)));
            w_last_nxt = ((w_x_nxt + LANES_S) > w_lim_x1) && (w_y_nxt == w_lim_y1);
        end else begin
            w_mask_nxt = {LANES{1'b0}};
            w_last_nxt = 1'b0;
        end
    end

    // Output, counter and bound registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_mask  <= {LANES{1'b0}};
            r_tex   <= 1'b0;
            r_x0    <= ZERO_S;
            r_x1    <= ZERO_S;
            r_y1    <= ZERO_S;
            r_u0    <= ZERO_U;
            r_x     <= ZERO_S;
            r_y     <= ZERO_S;
            r_u     <= ZERO_U;
            r_v     <= ZERO_U;
        end else begin
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_ack   <= (w_state_nxt == ST_DONE);
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_mask  <= w_mask_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_u     <= w_u_nxt;
            r_v     <= w_v_nxt;
            if (r_state == ST_SETUP) begin
                r_x0  <= w_b_x0;
                r_x1  <= w_b_x1;
                r_y1  <= w_b_y1;
                r_u0  <= texture_enable_i ? w_b_u0 : ZERO_U;
                r_tex <= texture_enable_i;
            end
        end
    end

    assign busy_o      = r_busy;
    assign ack_o       = r_ack;
    assign pix_valid_o = r_valid;
    assign x_o         = r_x[point_width-1:0];
    assign y_o         = r_y[point_width-1:0];
    assign u_o         = r_u;
    assign v_o         = r_v;
    assign lane_mask_o = r_mask;
    assign last_o      = r_last;

endmodule

// File: tb/tb_gfx_span_rasterizer.sv
// Self-checking bench for gfx_span_rasterizer: directed rects plus random
// commands with random backpressure against a span-list reference model.
module tb_gfx_span_rasterizer;

    localparam int PW = 16;
    localparam int LN = 4;

    typedef struct {
        int            x;
        int            y;
        int            u;
        int            v;
        logic [LN-1:0] mask;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          clip_en;
    logic          tex_en;
    logic [PW-1:0] d_p0_x, d_p0_y, d_p1_x, d_p1_y;
    logic [PW-1:0] c_p0_x, c_p0_y, c_p1_x, c_p1_y;
    logic [PW-1:0] s_p0_x, s_p0_y, s_p1_x, s_p1_y;
    logic          busy_o, ack_o, pix_valid_o, pix_ready_i, last_o;
    logic [PW-1:0] x_o, y_o, u_o, v_o;
    logic [LN-1:0] lane_mask_o;

    int    total = 0;
    int    bad   = 0;
    int    cmd[12];
    bit    cmd_ce;
    bit    cmd_te;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    gfx_span_rasterizer #(
        .point_width (PW),
        .LANES       (LN)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .clipping_enable_i (clip_en),
        .texture_enable_i  (tex_en),
        .dest_p0_x_i       (d_p0_x),
        .dest_p0_y_i       (d_p0_y),
        .dest_p1_x_i       (d_p1_x),
        .dest_p1_y_i       (d_p1_y),
        .clip_p0_x_i       (c_p0_x),
        .clip_p0_y_i       (c_p0_y),
        .clip_p1_x_i       (c_p1_x),
        .clip_p1_y_i       (c_p1_y),
        .src_p0_x_i        (s_p0_x),
        .src_p0_y_i        (s_p0_y),
        .src_p1_x_i        (s_p1_x),
        .src_p1_y_i        (s_p1_y),
        .busy_o            (busy_o),
        .ack_o             (ack_o),
        .pix_valid_o       (pix_valid_o),
        .pix_ready_i       (pix_ready_i),
        .x_o               (x_o),
        .y_o               (y_o),
        .u_o               (u_o),
        .v_o               (v_o),
        .lane_mask_o       (lane_mask_o),
        .last_o            (last_o)
    );

    task automatic load_cmd(input int dx0, input int dy0, input int dx1, input int dy1,
                            input int cx0, input int cy0, input int cx1, input int cy1,
                            input int sx0, input int sy0, input int sx1, input int sy1,
                            input bit ce, input bit te);
        cmd = '{dx0, dy0, dx1, dy1, cx0, cy0, cx1, cy1, sx0, sy0, sx1, sy1};
        cmd_ce = ce;
        cmd_te = te;
        d_p0_x = dx0[PW-1:0]; d_p0_y = dy0[PW-1:0];
        d_p1_x = dx1[PW-1:0]; d_p1_y = dy1[PW-1:0];
        c_p0_x = cx0[PW-1:0]; c_p0_y = cy0[PW-1:0];
        c_p1_x = cx1[PW-1:0]; c_p1_y = cy1[PW-1:0];
        s_p0_x = sx0[PW-1:0]; s_p0_y = sy0[PW-1:0];
        s_p1_x = sx1[PW-1:0]; s_p1_y = sy1[PW-1:0];
        clip_en = ce;
        tex_en  = te;
    endtask

    // Reference: list every beat of the span, row by row, from the rectangle rules.
    task automatic build_model();
        int    x0, x1, y0, y1, u0, v0, lim;
        beat_t b;
        exp_q.delete();
        x0 = cmd[0];
        if (cmd_ce && cmd[4] > x0) x0 = cmd[4];
        x1 = cmd[2] - 1;
        if (cmd_ce && cmd[6] - 1 < x1) x1 = cmd[6] - 1;
        y0 = cmd[1];
        if (cmd_ce && cmd[5] > y0) y0 = cmd[5];
        y1 = cmd[3] - 1;
        if (cmd_ce && cmd[7] - 1 < y1) y1 = cmd[7] - 1;
        u0 = cmd[8] + (x0 - cmd[0]);
        v0 = cmd[9] + (y0 - cmd[1]);
        if (cmd_te) begin
            lim = cmd[10] - 1 - u0;
            if (x0 + lim < x1) x1 = x0 + lim;
            lim = cmd[11] - 1 - v0;
            if (y0 + lim < y1) y1 = y0 + lim;
        end
        if (x0 <= x1 && y0 <= y1) begin
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1; x += LN) begin
                    b.x = x;
                    b.y = y;
                    b.u = cmd_te ? u0 + (x - x0) : 0;
                    b.v = cmd_te ? v0 + (y - y0) : 0;
                    for (int i = 0; i < LN; i++) b.mask[i] = (x + i <= x1);
                    b.last = (x + LN > x1) && (y == y1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Issue the loaded command and follow it to ack, checking every beat and all timing.
    task automatic run_cmd(input string name, input bit rand_ready, output int nbeats, output int masksum);
        int       cyc, n_exp, last_acc, budget;
        bit       done, stalled, first, rdy;
        logic [68:0] snap, got, want;
        beat_t    e;
        build_model();
        n_exp = exp_q.size();
        budget = 8 * n_exp + 20;
        nbeats = 0; masksum = 0; last_acc = 0;
        done = 0; stalled = 0; first = 1; snap = '0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        total++;
        if (busy_o !== 1'b1) begin
            bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_o);
        end
        while (!done && cyc < budget) begin
            got = {x_o, y_o, u_o, v_o, lane_mask_o, last_o};
            if (pix_valid_o) begin
                if (first) begin
                    total++;
                    if (cyc != 2) begin
                        bad++; $display("FAIL %s first_beat_latency: got %0d want 2", name, cyc);
                    end
                    first = 0;
                end
                if (stalled) begin
                    total++;
                    if (got !== snap) begin
                        bad++; $display("FAIL %s stall_hold: got %h want %h", name, got, snap);
                    end
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL %s extra_beat: got beat x=%0d y=%0d want none", name, x_o, y_o);
                end else begin
                    e = exp_q[0];
                    want = {e.x[PW-1:0], e.y[PW-1:0], e.u[PW-1:0], e.v[PW-1:0], e.mask, e.last};
                    if (got !== want) begin
                        bad++;
                        $display("FAIL %s beat: got x=%0d y=%0d u=%0d v=%0d m=%b l=%b want x=%0d y=%0d u=%0d v=%0d m=%b l=%b",
                                 name, $signed(x_o), $signed(y_o), u_o, v_o, lane_mask_o, last_o,
                                 e.x, e.y, e.u, e.v, e.mask, e.last);
                    end
                end
            end
            if (ack_o) begin
                total++;
                if (exp_q.size() != 0) begin
                    bad++; $display("FAIL %s ack_early: got %0d beats left want 0", name, exp_q.size());
                end
                total++;
                if (cyc != ((n_exp == 0) ? 2 : last_acc + 1)) begin
                    bad++; $display("FAIL %s ack_timing: got cycle %0d want %0d", name, cyc,
                                    (n_exp == 0) ? 2 : last_acc + 1);
                end
                done = 1;
            end
            rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_ready_i = rdy;
            if (pix_valid_o && rdy) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                nbeats++;
                masksum += $countones(lane_mask_o);
                last_acc = cyc;
                stalled = 0;
            end else if (pix_valid_o) begin
                stalled = 1;
                snap = got;
            end else begin
                stalled = 0;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s ack_timeout: got no ack in %0d cycles want ack", name, budget);
        end
        @(negedge clk);
        total++;
        if ({ack_o, busy_o, pix_valid_o} !== 3'b000) begin
            bad++; $display("FAIL %s after_ack: got ack/busy/valid=%b want 000", name, {ack_o, busy_o, pix_valid_o});
        end
        pix_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; pix_ready_i = 1'b0;
        load_cmd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if ({busy_o, ack_o, pix_valid_o, last_o, lane_mask_o, x_o, y_o, u_o, v_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: got busy=%b ack=%b valid=%b x=%0d want all 0", busy_o, ack_o, pix_valid_o, x_o);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy_o, ack_o, pix_valid_o} !== 3'b000) begin
            bad++; $display("FAIL idle_no_start: got busy/ack/valid=%b want 000", {busy_o, ack_o, pix_valid_o});
        end
    endtask

    task automatic test_basic_rect();
        int nb, ms;
        load_cmd(0, 0, 10, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_cmd("basic", 1'b0, nb, ms);
        total++;
        if (nb != 6 || ms != 20) begin
            bad++; $display("FAIL basic_count: got beats=%0d masks=%0d want 6/20", nb, ms);
        end
    endtask

    task automatic test_clip();
        int nb, ms;
        load_cmd(-4, -4, 20, 20, 2, 1, 5, 3, 0, 0, 0, 0, 1'b1, 1'b0);
        run_cmd("clip", 1'b0, nb, ms);
        total++;
        if (nb != 2 || ms != 6) begin
            bad++; $display("FAIL clip_count: got beats=%0d masks=%0d want 2/6", nb, ms);
        end
    endtask

    task automatic test_texture();
        int nb, ms;
        load_cmd(0, 0, 16, 16, 0, 0, 0, 0, 8, 8, 11, 10, 1'b0, 1'b1);
        run_cmd("texture", 1'b0, nb, ms);
        total++;
        if (nb != 2 || ms != 6) begin
            bad++; $display("FAIL texture_count: got beats=%0d masks=%0d want 2/6", nb, ms);
        end
    endtask

    task automatic test_empty();
        int nb, ms;
        load_cmd(5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_cmd("empty", 1'b0, nb, ms);
        total++;
        if (nb != 0) begin
            bad++; $display("FAIL empty_count: got beats=%0d want 0", nb);
        end
    endtask

    task automatic test_backpressure();
        int nb, ms;
        load_cmd(0, 0, 10, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_cmd("bp_basic", 1'b1, nb, ms);
        total++;
        if (nb != 6 || ms != 20) begin
            bad++; $display("FAIL bp_count: got beats=%0d masks=%0d want 6/20", nb, ms);
        end
        load_cmd(-3, 1, 13, 6, 0, 0, 0, 0, 4, 2, 30, 30, 1'b0, 1'b1);
        run_cmd("bp_texture", 1'b1, nb, ms);
    endtask

    task automatic test_random();
        int nb, ms, dx0, dy0, cx0, cy0, sx0, sy0;
        for (int k = 0; k < 14; k++) begin
            dx0 = int'($urandom_range(0, 30)) - 8;
            dy0 = int'($urandom_range(0, 12)) - 4;
            cx0 = int'($urandom_range(0, 16));
            cy0 = int'($urandom_range(0, 8));
            sx0 = int'($urandom_range(0, 20));
            sy0 = int'($urandom_range(0, 20));
            load_cmd(dx0, dy0, dx0 + int'($urandom_range(0, 24)) - 2, dy0 + int'($urandom_range(0, 8)) - 1,
                     cx0, cy0, cx0 + int'($urandom_range(0, 16)), cy0 + int'($urandom_range(0, 8)),
                     sx0, sy0, sx0 + int'($urandom_range(0, 20)), sy0 + int'($urandom_range(0, 8)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_cmd("random", 1'b1, nb, ms);
        end
    endtask

    task automatic test_reset_mid_run();
        int nb, ms;
        load_cmd(0, 0, 40, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        pix_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (pix_valid_o !== 1'b1) begin
            bad++; $display("FAIL midrun_valid: got %b want 1", pix_valid_o);
        end
        rst_i = 1'b1;
        @(negedge clk);
        total++;
        if ({busy_o, ack_o, pix_valid_o, last_o, lane_mask_o, x_o, y_o, u_o, v_o} !== '0) begin
            bad++; $display("FAIL midrun_reset_outputs: got busy=%b ack=%b valid=%b x=%0d want all 0", busy_o, ack_o, pix_valid_o, x_o);
        end
        rst_i = 1'b0;
        pix_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({ack_o, busy_o, pix_valid_o} !== 3'b000) begin
                bad++; $display("FAIL midrun_no_ack: got ack/busy/valid=%b want 000", {ack_o, busy_o, pix_valid_o});
            end
        end
        load_cmd(0, 0, 10, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_cmd("after_reset", 1'b0, nb, ms);
        total++;
        if (nb != 6) begin
            bad++; $display("FAIL after_reset_count: got beats=%0d want 6", nb);
        end
    endtask

    task automatic test_back_to_back();
        int nb, ms;
        load_cmd(1, 0, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        run_cmd("b2b_a", 1'b0, nb, ms);
        load_cmd(2, 2, 3, 3, 0, 0, 0, 0, 5, 6, 9, 9, 1'b0, 1'b1);
        run_cmd("b2b_b", 1'b0, nb, ms);
        total++;
        if (nb != 1 || ms != 1) begin
            bad++; $display("FAIL b2b_single_pixel: got beats=%0d masks=%0d want 1/1", nb, ms);
        end
    endtask

    initial begin
        test_reset();
        test_basic_rect();
        test_clip();
        test_texture();
        test_empty();
        test_backpressure();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
